// File: rtl/serial_pattern_gen_if.sv
// serial_pattern_gen_if: control inputs and serial outputs of the pattern transmitter
interface serial_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int RPT_W = 4,
    parameter int LW = $clog2(WIDTH + 1)
);
    logic start;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0] len;
    logic [RPT_W-1:0] rpt;
    logic gap;
    logic sout;
    logic valid;
    logic busy;
    logic done;
    logic err;
    modport master(output start, pattern, len, rpt, gap, input sout, valid, busy, done, err);
    modport slave(input start, pattern, len, rpt, gap, output sout, valid, busy, done, err);
endinterface

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: loads a 1..WIDTH bit pattern and shifts it out MSB-first,
// optionally repeated with one idle cycle between repetitions
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int RPT_W = 4,
    parameter int LW = $clog2(WIDTH + 1)
) (
    input logic clock,
    input logic rst,
    serial_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);
    state_t state, state_n;
    logic [WIDTH-1:0] pat, pat_n, src;
    logic [LW-1:0] ln, ln_n, idx, idx_n;
    logic [RPT_W-1:0] rc, rc_n;
    logic gp, gp_n, legal, sout_n, valid_n, busy_n, done_n, err_n;
    always_comb begin
        legal = bus.len != '0 && bus.len <= LEN_MAX;
        state_n = state;
        pat_n = pat;
        ln_n = ln;
        rc_n = rc;
        gp_n = gp;
        idx_n = idx;
        src = pat;
        valid_n = 1'b0;
        busy_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                if (legal) begin
                    state_n = SHIFT;
                    pat_n = bus.pattern;
                    ln_n = bus.len;
                    rc_n = bus.rpt;
                    gp_n = bus.gap;
                    idx_n = bus.len - 1'b1;
                    src = bus.pattern;
                    valid_n = 1'b1;
                    busy_n = 1'b1;
                end else err_n = 1'b1;
            end
            SHIFT: begin
                busy_n = 1'b1;
                if (idx != '0) begin
                    idx_n = idx - 1'b1;
                    valid_n = 1'b1;
                end else if (rc == '0) begin
                    state_n = IDLE;
                    busy_n = 1'b0;
                end else begin
                    rc_n = rc - 1'b1;
                    state_n = gp ? GAP : SHIFT;
                    idx_n = gp ? idx : ln - 1'b1;
                    valid_n = !gp;
                end
            end
            GAP: begin
                state_n = SHIFT;
                idx_n = ln - 1'b1;
                valid_n = 1'b1;
                busy_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // done marks the bit that leaves both the index and repeat counter at zero
        sout_n = valid_n && |(src & (WIDTH'(1) << idx_n));
        done_n = valid_n && idx_n == '0 && rc_n == '0;
    end
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pat <= '0;
            ln <= '0;
            rc <= '0;
            gp <= 1'b0;
            idx <= '0;
            bus.sout <= 1'b0;
            bus.valid <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            state <= state_n;
            pat <= pat_n;
            ln <= ln_n;
            rc <= rc_n;
            gp <= gp_n;
            idx <= idx_n;
            bus.sout <= sout_n;
            bus.valid <= valid_n;
            bus.busy <= busy_n;
            bus.done <= done_n;
            bus.err <= err_n;
        end
    end
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: scoreboard bench; expected bit streams come from a list-based model
module tb_serial_pattern_gen;
    typedef struct packed {logic b; logic d;} exp_t;
    logic clock = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    serial_pattern_gen_if bus();
    serial_pattern_gen dut (.clock(clock), .rst(rst), .bus(bus));
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected stream: every repetition emits pattern[len-1] down to pattern[0]
    task automatic push_model(input logic [7:0] p, input int l, input int r);
        for (int k = 0; k <= r; k++)
            for (int j = l - 1; j >= 0; j--)
                exp_q.push_back('{b: p[j], d: (k == r && j == 0)});
    endtask

    task automatic send(input logic [7:0] p, input int l, input int r, input bit g);
        int n;
        @(negedge clock);
        bus.start = 1'b1;
        bus.pattern = p;
        bus.len = 4'(l);
        bus.rpt = 4'(r);
        bus.gap = g;
        if (l >= 1 && l <= 8) push_model(p, l, r);
        @(negedge clock);
        bus.start = 1'b0;
        bus.pattern = 8'($urandom);
        bus.len = 4'($urandom);
        bus.rpt = 4'($urandom);
        bus.gap = 1'($urandom);
        if (l < 1 || l > 8) begin
            chk("err_rise", {bus.err, bus.busy, bus.valid, bus.sout}, 4'b1000);
            @(negedge clock);
            chk("err_fall", {bus.err, bus.busy, bus.valid, bus.sout}, 4'b0000);
        end else begin
            chk("no_err", bus.err, 0);
            n = 0;
            while (bus.busy && n < 400) begin
                n++;
                @(negedge clock);
            end
            chk("busy_cycles", n, (r + 1) * l + r * int'(g));
            chk("queue_drained", exp_q.size(), 0);
        end
    endtask

    task automatic held_start();
        int n;
        @(negedge clock);
        bus.start = 1'b1;
        bus.pattern = 8'h5A;
        bus.len = 4'd6;
        bus.rpt = 4'd1;
        bus.gap = 1'b1;
        push_model(8'h5A, 6, 1);
        n = 0;
        @(negedge clock);
        while (bus.busy && n < 100) begin
            bus.pattern = 8'($urandom);
            bus.len = 4'($urandom_range(1, 8));
            bus.rpt = 4'($urandom_range(0, 3));
            bus.gap = 1'($urandom);
            n++;
            @(negedge clock);
        end
        chk("held_busy1", n, 13);
        bus.pattern = 8'hC3;
        bus.len = 4'd5;
        bus.rpt = 4'd0;
        bus.gap = 1'b0;
        push_model(8'hC3, 5, 0);
        @(negedge clock);
        chk("held_restart", bus.busy, 1);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("held_busy2", n, 5);
        chk("held_drained", exp_q.size(), 0);
    endtask

    task automatic reset_mid();
        @(negedge clock);
        bus.start = 1'b1;
        bus.pattern = 8'h06;
        bus.len = 4'd3;
        bus.rpt = 4'd2;
        bus.gap = 1'b0;
        push_model(8'h06, 3, 2);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        #1 rst = 1'b0;
        #1 chk("rst_async", {bus.sout, bus.valid, bus.busy, bus.done}, 4'b0000);
        exp_q.delete();
        @(negedge clock);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("rst_stay_idle", {bus.sout, bus.valid, bus.busy, bus.done}, 4'b0000);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clock);
        if (bus.valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream: unexpected bit sout=%0b done=%0b expected none", bus.sout, bus.done);
            end else begin
                e = exp_q.pop_front();
                chk("stream_bit_done", {bus.sout, bus.done}, {e.b, e.d});
            end
        end else chk("idle_outputs", {bus.sout, bus.done}, 2'b00);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int l, r;
        bus.start = 1'b0;
        bus.pattern = '0;
        bus.len = '0;
        bus.rpt = '0;
        bus.gap = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", {bus.sout, bus.valid, bus.busy, bus.done, bus.err}, 5'b0);
        rst = 1'b1;
        @(negedge clock);
        send(8'h06, 3, 0, 1'b0);
        send(8'h06, 3, 2, 1'b0);
        send(8'h06, 3, 2, 1'b1);
        send(8'hA5, 8, 0, 1'b0);
        send(8'h01, 0, 0, 1'b0);
        send(8'hFF, 9, 1, 1'b0);
        send(8'h01, 1, 15, 1'b0);
        send(8'h02, 2, 15, 1'b1);
        held_start();
        reset_mid();
        for (int i = 0; i < 40; i++) begin
            l = $urandom_range(0, 9);
            r = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            send(8'($urandom), l, r, 1'($urandom));
        end
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Serial bit-pattern transmitter: the driving end of the serial sequence-detection path. It loads a parallel pattern of 1..WIDTH bits and shifts it out MSB-first, one bit per clock, on a single serial line. The pattern can be repeated a programmed number of times, optionally with one idle cycle between repetitions. It sources stimulus for the 110 sequence detector and for any other serial-input detector in the design.

## Interface

- WIDTH, 8, maximum pattern length in bits.
- RPT_W, 4, width of the repeat-count input.
- LW, $clog2(WIDTH+1), width of the length input (derived; do not override).

- clock  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low: 0 = reset.
- start  in  1  request a transfer; sampled on a rising edge while idle.
- pattern  in  WIDTH  bits to send; the low len bits are used.
- len  in  LW  number of bits per repetition; legal range is 1..WIDTH.
- rpt  in  RPT_W  extra repetitions; 0 = send once.
- gap  in  1  1 = insert one idle cycle between repetitions.
- sout  out  1  serial data; 0 whenever valid=0.
- valid  out  1  sout carries a pattern bit this cycle.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse, coincident with the final bit.
- err  out  1  one-cycle pulse when a start has an illegal len.

## Operation

- State machine: IDLE, SHIFT, GAP. All outputs are registered.
- Reset values: state=IDLE, sout=0, valid=0, busy=0, done=0, err=0. Internal counters are 0.
- IDLE, start=1, len in 1..WIDTH:
  - Latch pattern, len, rpt and gap.
  - Set the bit index to len-1 and the repeat counter to rpt.
  - Drive sout=pattern[len-1], valid=1, busy=1, and go to SHIFT.
- IDLE, start=1, illegal len (len=0 or len>WIDTH): pulse err for one cycle, stay in IDLE, keep busy=0.
- IDLE, start=0: hold all outputs at their reset values.
- SHIFT, bit index >0: decrement the index and drive the next lower bit.
- SHIFT, bit index =0:
  - Repeat counter >0 and gap=0: decrement the counter, reload the index to len-1, and drive pattern[len-1] on the next cycle. Output is continuous, with no bubble.
  - Repeat counter >0 and gap=1: decrement the counter and go to GAP.
  - Repeat counter =0: done=1 in this cycle, then go to IDLE next.
- GAP: for one cycle drive valid=0, sout=0, busy=1. Then reload the index, go to SHIFT and drive pattern[len-1].
- start is ignored in SHIFT and GAP, including in the done cycle.
- Changes to pattern, len, rpt or gap after acceptance have no effect until the next accepted start.
- Arithmetic rules:
  - The bit index is LW bits wide and counts down; it never wraps below 0.
  - The repeat counter is RPT_W bits; rpt at its maximum value gives 2^RPT_W repetitions total.
  - Total busy cycles = (rpt+1)*len + rpt*gap.
- Reset mid-operation: all outputs clear asynchronously. After reset is released the block stays in IDLE; the transfer does not resume.

## Timing

- start sampled at rising edge k: bit j of the stream (j=0 first) is driven from edge k+j to edge k+j+1. Downstream logic samples bit j at edge k+j+1.
- First bit latency: one edge.
- done and the final bit share the same cycle. busy falls at the following edge.
- Minimum spacing: a new start is accepted no earlier than the edge after busy falls, so there is at least one idle cycle between transfers.
- err rises one edge after the illegal start is sampled and lasts one cycle.

## Test plan

- Single 110: pattern=8'h06, len=3, rpt=0, gap=0 → sout=1,1,0 with valid=1 for 3 cycles, done on the third, busy low afterwards. Looped into the 110 detector, its output goes to 1 one cycle after the final 0.
- Continuous repeat: pattern=3'b110, len=3, rpt=2, gap=0 → 110110110 with valid held for 9 cycles and done on cycle 9. Same settings with gap=1 → 11 cycles, valid=0 and sout=0 on cycles 4 and 8.
- Full width: pattern=8'hA5, len=8 → 10100101, MSB-first, done on cycle 8.
- Illegal length: len=0, and separately len=9 (WIDTH=8) → err pulse of exactly 1 cycle; busy, valid and sout all stay 0.
- start held high throughout a transfer with pattern changed mid-stream → the first stream is unaffected. The second transfer starts exactly one idle cycle after done and uses the pattern value present at acceptance.
- Reset during cycle 4 of a 9-cycle transfer → sout, valid, busy and done go to 0 without waiting for a clock edge. After release they stay 0 until the next start.
